coherence_ctrl_n: RTL and testbench

N-CPU successor to the two-CPU cache controller. Sits between per-CPU icache/dcache ports and the single RAM port. Arbitrates icache and dcache traffic across CPUS processors and serialises all RAM access. Runs an MSI snoop protocol: broadcasts snoop/invalidate, and forwards Modified data cache-to-cache while writing it back to RAM.

---
 rtl/coherence_ctrl_n.sv | 249 ++++++++++++++++++++++++
 tb/tb_coherence_ctrl_n.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/coherence_ctrl_n.sv
// coherence_ctrl_n: N-CPU MSI snoop controller in front of a single RAM port.
// Arbitrates icache/dcache requests (dcache class first), serialises RAM
// traffic, broadcasts snoops and forwards Modified lines cache-to-cache.
// Optional macro CC_ROUND_ROBIN_EN: round-robin within a class; when it is
// undefined, arbitration is fixed priority (lowest cpuid) with no pointer.
//
// Handshake: a requester raises iREN/dREN/dWEN and holds it; its *wait output
// stays 1 until the transfer completes, then drops to 0 for exactly one cycle
// (load data valid in that cycle). RAM completes on ramstate ACCESS or ERROR.
module coherence_ctrl_n #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [CPUS-1:0]          iREN,
  input  logic [CPUS*WORD_W-1:0]   iaddr,
  output logic [CPUS-1:0]          iwait,
  output logic [CPUS*WORD_W-1:0]   iload,
  input  logic [CPUS-1:0]          dREN,
  input  logic [CPUS-1:0]          dWEN,
  input  logic [CPUS*WORD_W-1:0]   daddr,
  input  logic [CPUS*WORD_W-1:0]   dstore,
  output logic [CPUS-1:0]          dwait,
  output logic [CPUS*WORD_W-1:0]   dload,
  input  logic [CPUS-1:0]          cctrans,
  input  logic [CPUS-1:0]          ccwrite,
  output logic [CPUS-1:0]          ccwait,
  output logic [CPUS-1:0]          ccinv,
  output logic [CPUS*WORD_W-1:0]   ccsnoopaddr,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [WORD_W-1:0]        ramaddr,
  output logic [WORD_W-1:0]        ramstore,
  input  logic [WORD_W-1:0]        ramload,
  input  logic [1:0]               ramstate,
  output logic [2:0]               dbg_state
);

  localparam int CW = $clog2(CPUS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARB    = 3'd1,
    S_IFETCH = 3'd2,
    S_DWRITE = 3'd3,
    S_SNOOP  = 3'd4,
    S_FWD    = 3'd5,
    S_DFILL  = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] gnt_q, gnt_d;
  logic [CW-1:0] resp_q, resp_d;
  logic          snp_cnt_q, snp_cnt_d;

  logic [WORD_W-1:0] iaddr_a [CPUS];
  logic [WORD_W-1:0] daddr_a [CPUS];
  logic [WORD_W-1:0] dstore_a [CPUS];
  logic [WORD_W-1:0] iload_a [CPUS];
  logic [WORD_W-1:0] dload_a [CPUS];
  logic [WORD_W-1:0] snp_a [CPUS];

  logic [CPUS-1:0] dreq, areq;
  logic            arb_found;
  logic [CW-1:0]   arb_idx;
  int              arb_pos;
  logic            resp_hit;
  logic [CW-1:0]   resp_idx;
  logic            ram_done;
  logic            txn_done;

  // Pack/unpack per-CPU word buses
  for (genvar c = 0; c < CPUS; c++) begin : g_words
    assign iaddr_a[c]  = iaddr[c*WORD_W +: WORD_W];
    assign daddr_a[c]  = daddr[c*WORD_W +: WORD_W];
    assign dstore_a[c] = dstore[c*WORD_W +: WORD_W];
    assign iload[c*WORD_W +: WORD_W]       = iload_a[c];
    assign dload[c*WORD_W +: WORD_W]       = dload_a[c];
    assign ccsnoopaddr[c*WORD_W +: WORD_W] = snp_a[c];
  end

  assign ram_done  = (ramstate == 2'd2) || (ramstate == 2'd3);
  assign dbg_state = state_q;

`ifdef CC_ROUND_ROBIN_EN
  // Pointer holds the cpuid searched first; it moves past the winner on completion
  logic [CW-1:0] ptr_q, ptr_d;

  // Round-robin pointer register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  // Advance pointer to (granted + 1) mod CPUS when a transaction completes
  always_comb begin
    ptr_d = ptr_q;
    if (txn_done) ptr_d = (gnt_q == CW'(CPUS-1)) ? '0 : gnt_q + 1'b1;
  end
`endif

  // Arbiter: dcache class wins outright, then search within the winning class
  always_comb begin
    dreq      = dREN | dWEN;
    areq      = (|dreq) ? dreq : iREN;
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_pos   = 0;
    for (int k = 0; k < CPUS; k++) begin
`ifdef CC_ROUND_ROBIN_EN
      arb_pos = int'(ptr_q) + k;
      if (arb_pos >= CPUS) arb_pos = arb_pos - CPUS;
`else
      arb_pos = k;
`endif
      if (!arb_found && areq[CW'(arb_pos)]) begin
        arb_found = 1'b1;
        arb_idx   = CW'(arb_pos);
      end
    end
  end

  // Snoop responder: lowest other CPU writing back a Modified line
  always_comb begin
    resp_hit = 1'b0;
    resp_idx = '0;
    for (int j = 0; j < CPUS; j++) begin
      if (!resp_hit && CW'(j) != gnt_q && dWEN[CW'(j)] && ccwrite[CW'(j)]) begin
        resp_hit = 1'b1;
        resp_idx = CW'(j);
      end
    end
  end

  // FSM state, grant, responder and snoop-cycle registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      resp_q    <= '0;
      snp_cnt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      resp_q    <= resp_d;
      snp_cnt_q <= snp_cnt_d;
    end
  end

  // Next-state and all outputs; outputs are a function of the registered state
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    resp_d    = resp_q;
    snp_cnt_d = 1'b0;
    txn_done  = 1'b0;
    iwait     = '1;
    dwait     = '1;
    ccwait    = '0;
    ccinv     = '0;
    iload_a   = '{default: '0};
    dload_a   = '{default: '0};
    snp_a     = '{default: '0};
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    case (state_q)
      S_IDLE: begin
        if (|(dREN | dWEN | iREN)) state_d = S_ARB;
      end
      S_ARB: begin
        if (!arb_found) begin
          state_d = S_IDLE;
        end else begin
          gnt_d = arb_idx;
          if (|dreq) begin
            if (dWEN[arb_idx])         state_d = S_DWRITE;
            else if (cctrans[arb_idx]) state_d = S_SNOOP;
            else                       state_d = S_DFILL;
          end else begin
            state_d = S_IFETCH;
          end
        end
      end
      S_IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr_a[gnt_q];
        if (ram_done) begin
          iwait[gnt_q]   = 1'b0;
          iload_a[gnt_q] = ramload;
          txn_done       = 1'b1;
          state_d        = S_IDLE;
        end
      end
      S_DWRITE: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr_a[gnt_q];
        ramstore = dstore_a[gnt_q];
        if (ram_done) begin
          dwait[gnt_q] = 1'b0;
          txn_done     = 1'b1;
          state_d      = S_IDLE;
        end
      end
      S_SNOOP: begin
        for (int j = 0; j < CPUS; j++) begin
          if (CW'(j) != gnt_q) begin
            ccwait[CW'(j)] = 1'b1;
            ccinv[CW'(j)]  = ccwrite[gnt_q];
            snp_a[j]       = daddr_a[gnt_q];
          end
        end
        // First cycle arms the counter; responses are judged in the second
        if (!snp_cnt_q) begin
          snp_cnt_d = 1'b1;
        end else begin
          resp_d  = resp_idx;
          state_d = resp_hit ? S_FWD : S_DFILL;
        end
      end
      S_FWD: begin
        dload_a[gnt_q] = dstore_a[resp_q];
        ramWEN         = 1'b1;
        ramaddr        = daddr_a[gnt_q];
        ramstore       = dstore_a[resp_q];
        if (ram_done) begin
          dwait[gnt_q]  = 1'b0;
          dwait[resp_q] = 1'b0;
          txn_done      = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_DFILL: begin
        ramREN  = 1'b1;
        ramaddr = daddr_a[gnt_q];
        if (ram_done) begin
          dwait[gnt_q]   = 1'b0;
          dload_a[gnt_q] = ramload;
          txn_done       = 1'b1;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_coherence_ctrl_n.sv
// Directed testbench for coherence_ctrl_n with CPUS=4. Inputs change on the
// falling edge; outputs are checked 1 ns later with immediate assertions.
module tb_coherence_ctrl_n;

  localparam int CPUS = 4;
  localparam int W    = 32;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SNOOP = 3'd4;
  localparam logic [2:0] ST_FWD   = 3'd5;
  localparam logic [2:0] ST_DFILL = 3'd6;

  logic              CLK, nRST;
  logic [CPUS-1:0]   iREN, iwait, dREN, dWEN, dwait;
  logic [CPUS-1:0]   cctrans, ccwrite, ccwait, ccinv;
  logic [CPUS*W-1:0] iaddr, iload, daddr, dstore, dload, ccsnoopaddr;
  logic              ramREN, ramWEN;
  logic [W-1:0]      ramaddr, ramstore, ramload;
  logic [1:0]        ramstate;
  logic [2:0]        dbg_state;

  int n_chk  = 0;
  int n_fail = 0;

  coherence_ctrl_n #(.CPUS(CPUS), .WORD_W(W)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .dbg_state(dbg_state)
  );

  // Clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] wd(input logic [CPUS*W-1:0] v, input int c);
    return v[c*W +: W];
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Step falling edges until a RAM strobe appears (bounded)
  task automatic wait_strobe(input string tag);
    int n;
    n = 0;
    @(negedge CLK); #1;
    while (!(ramREN || ramWEN) && n < 20) begin
      @(negedge CLK); #1;
      n++;
    end
    chk(tag, W'(ramREN || ramWEN), 32'd1);
  endtask

  // One BUSY cycle, then present the completing ramstate and load data
  task automatic go_access(input logic [1:0] st, input logic [W-1:0] ld);
    ramstate = 2'd1;
    @(negedge CLK);
    ramstate = st;
    ramload  = ld;
    #1;
  endtask

  task automatic next_free();
    @(negedge CLK);
    ramstate = 2'd0;
    ramload  = '0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    int n;
    logic [CPUS-1:0] exp_w;
    nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    daddr = '0; dstore = '0; ramload = '0; ramstate = 2'd0;
    for (int c = 0; c < CPUS; c++) iaddr[c*W +: W] = 32'h1000 + 32'(c) * 32'h10;

    // Reset state
    @(negedge CLK); #1;
    chk("rst_iwait",  W'(iwait), 32'hF);
    chk("rst_dwait",  W'(dwait), 32'hF);
    chk("rst_ram",    W'({ramREN, ramWEN}), 32'd0);
    chk("rst_state",  W'(dbg_state), W'(ST_IDLE));
    chk("rst_iload",  wd(iload, 1), 32'd0);
    chk("rst_cc",     W'({ccwait, ccinv}), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // 1: iREN[1] and iREN[3]; CPU1 first, then CPU3
    iREN = 4'b1010;
    wait_strobe("t1_strobe1");
    chk("t1_ramaddr1", ramaddr, 32'h1010);
    chk("t1_busy_iwait", W'(iwait), 32'hF);
    go_access(2'd2, 32'h1111_AAAA);
    chk("t1_iwait1", W'(iwait), 32'hD);
    chk("t1_iload1", wd(iload, 1), 32'h1111_AAAA);
    chk("t1_iload3", wd(iload, 3), 32'd0);
    next_free();
    iREN = 4'b1000;
    #1;
    chk("t1_iwait_back", W'(iwait), 32'hF);
    wait_strobe("t1_strobe3");
    chk("t1_ramaddr3", ramaddr, 32'h1030);
    go_access(2'd2, 32'h3333_BBBB);
    chk("t1_iwait3", W'(iwait), 32'h7);
    chk("t1_iload3b", wd(iload, 3), 32'h3333_BBBB);
    next_free();
    iREN = '0;

    // 2: iREN[0] with dWEN[2]; the write goes first, ERROR completes it
    iREN = 4'b0001;
    dWEN = 4'b0100;
    daddr[2*W +: W]  = 32'h100;
    dstore[2*W +: W] = 32'hDEAD;
    wait_strobe("t2_strobe_w");
    chk("t2_ramWEN", W'({ramREN, ramWEN}), 32'd1);
    chk("t2_ramaddr", ramaddr, 32'h100);
    chk("t2_ramstore", ramstore, 32'hDEAD);
    go_access(2'd3, 32'h0);
    chk("t2_dwait", W'(dwait), 32'hB);
    chk("t2_iwait", W'(iwait), 32'hF);
    next_free();
    dWEN = '0;
    wait_strobe("t2_strobe_r");
    chk("t2_ifetch", W'({ramREN, ramWEN}), 32'd2);
    chk("t2_ifetch_addr", ramaddr, 32'h1000);
    go_access(2'd2, 32'h0000_5A5A);
    chk("t2_iwait0", W'(iwait), 32'hE);
    chk("t2_iload0", wd(iload, 0), 32'h0000_5A5A);
    next_free();
    iREN = '0;

    // 3: BusRdX snoop from CPU0 at 0x40; nobody responds -> fill from RAM
    dREN = 4'b0001; cctrans = 4'b0001; ccwrite = 4'b0001;
    daddr[0*W +: W] = 32'h40;
    n = 0;
    @(negedge CLK); #1;
    while (ccwait == '0 && n < 20) begin
      @(negedge CLK); #1;
      n++;
    end
    chk("t3_ccwait_c1", W'(ccwait), 32'hE);
    chk("t3_ccinv", W'(ccinv), 32'hE);
    chk("t3_snp1", wd(ccsnoopaddr, 1), 32'h40);
    chk("t3_snp3", wd(ccsnoopaddr, 3), 32'h40);
    chk("t3_snp0", wd(ccsnoopaddr, 0), 32'h0);
    chk("t3_noram", W'({ramREN, ramWEN}), 32'd0);
    @(negedge CLK); #1;
    chk("t3_ccwait_c2", W'(ccwait), 32'hE);
    chk("t3_state_c2", W'(dbg_state), W'(ST_SNOOP));
    @(negedge CLK); #1;
    chk("t3_ccwait_end", W'(ccwait), 32'h0);
    chk("t3_state_fill", W'(dbg_state), W'(ST_DFILL));
    chk("t3_ramREN", W'({ramREN, ramWEN}), 32'd2);
    chk("t3_ramaddr", ramaddr, 32'h40);
    go_access(2'd2, 32'h1234_5678);
    chk("t3_dwait", W'(dwait), 32'hE);
    chk("t3_dload0", wd(dload, 0), 32'h1234_5678);
    next_free();
    dREN = '0; cctrans = '0; ccwrite = '0;

    // 4: BusRd snoop from CPU0; CPU2 holds the line Modified and forwards it
    dREN = 4'b0001; cctrans = 4'b0001; ccwrite = 4'b0000;
    n = 0;
    @(negedge CLK); #1;
    while (ccwait == '0 && n < 20) begin
      @(negedge CLK); #1;
      n++;
    end
    chk("t4_ccwait", W'(ccwait), 32'hE);
    chk("t4_ccinv", W'(ccinv), 32'h0);
    dWEN = 4'b0100; ccwrite = 4'b0100;
    dstore[2*W +: W] = 32'hBEEF;
    @(negedge CLK); #1;
    chk("t4_snp2", wd(ccsnoopaddr, 2), 32'h40);
    @(negedge CLK); #1;
    chk("t4_state_fwd", W'(dbg_state), W'(ST_FWD));
    chk("t4_ramWEN", W'({ramREN, ramWEN}), 32'd1);
    chk("t4_ramaddr", ramaddr, 32'h40);
    chk("t4_ramstore", ramstore, 32'hBEEF);
    chk("t4_dload0", wd(dload, 0), 32'hBEEF);
    chk("t4_dwait_hold", W'(dwait), 32'hF);
    go_access(2'd2, 32'h0);
    chk("t4_dwait_both", W'(dwait), 32'hA);
    next_free();
    dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    #1;
    chk("t4_dwait_back", W'(dwait), 32'hF);

    // 5: all four CPUs hold iREN; expected grant order depends on the build
    do_reset();
    iREN = 4'b1111;
    for (int k = 0; k < 5; k++) begin
`ifdef CC_ROUND_ROBIN_EN
      exp_w = ~(4'b0001 << (k % CPUS));
`else
      exp_w = 4'b1110;
`endif
      wait_strobe("t5_strobe");
      go_access(2'd2, 32'hC0DE_0000 + 32'(k));
      chk("t5_grant", W'(iwait), W'(exp_w));
      next_free();
    end
    iREN = '0;

    // 6: reset asserted during a plain DFILL aborts it immediately
    dREN = 4'b0010;
    daddr[1*W +: W] = 32'h80;
    wait_strobe("t6_strobe");
    chk("t6_fill_addr", ramaddr, 32'h80);
    chk("t6_state_fill", W'(dbg_state), W'(ST_DFILL));
    ramstate = 2'd1;
    #2;
    nRST = 1'b0;
    #1;
    chk("t6_ram_off", W'({ramREN, ramWEN}), 32'd0);
    chk("t6_waits", W'({iwait, dwait}), 32'hFF);
    chk("t6_state_rst", W'(dbg_state), W'(ST_IDLE));
    @(negedge CLK);
    dREN = '0;
    ramstate = 2'd0;
    nRST = 1'b1;
    @(negedge CLK); #1;
    chk("t6_state_after", W'(dbg_state), W'(ST_IDLE));
    chk("t6_ram_after", W'({ramREN, ramWEN}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
